// File: rtl/i2c_touch_slave.sv
// I2C target emulating a touch controller register window: device address match,
// 16-bit register pointer with auto-increment, byte reads/writes, user-side update port.
module i2c_touch_slave #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h14,
   parameter logic [15:0] BASE_ADDR  = 16'h8140,
   parameter int          DEPTH      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic        usr_we,
   input  logic [15:0] usr_addr,
   input  logic [7:0]  usr_wdata,
   output logic        wr_valid,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   // state      | meaning
   // IDLE       | waiting for START
   // DEV        | receiving device address + R/W
   // DEV_ACK    | driving ACK for a matched address
   // PTR_HI/LO  | receiving pointer high/low byte
   // *_ACK      | driving ACK for the byte just received
   // WR         | receiving a data byte to store at the pointer
   // RD         | shifting out the byte latched from the pointer
   // RD_ACK     | SDA released, sampling the initiator's ACK/NACK
   typedef enum logic [3:0] {
      S_IDLE, S_DEV, S_DEV_ACK, S_PTR_HI, S_PTR_HI_ACK, S_PTR_LO, S_PTR_LO_ACK,
      S_WR, S_WR_ACK, S_RD, S_RD_ACK
   } state_t;

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t      r_state, w_state_nxt;
   logic        r_scl_s1, r_scl_s2, r_scl_h;
   logic        r_sda_s1, r_sda_s2, r_sda_h;
   logic [2:0]  r_cnt;
   logic        r_done;
   logic [7:0]  r_shift;
   logic [7:0]  r_rd_shift;
   logic [15:0] r_ptr;
   logic        r_sda_oe, w_sda_oe_nxt;
   logic        r_wr_valid;
   logic [15:0] r_wr_addr;
   logic [7:0]  r_wr_data;
   logic        r_busy;
   logic [7:0]  r_mem [DEPTH];

   logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_rise, w_fall, w_bit;
   logic        w_rx_state, w_cnt_state, w_match, w_wr_byte_end;
   logic        w_rd_load, w_rd_shift;
   logic [15:0] w_ptr_off, w_usr_off;
   logic        w_ptr_in, w_usr_in;
   logic [AW-1:0] w_ptr_idx, w_usr_idx;
   logic [7:0]  w_rd_byte, w_wr_byte;

   assign w_scl_rise = r_scl_s2 & ~r_scl_h;
   assign w_scl_fall = ~r_scl_s2 & r_scl_h;
   assign w_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
   assign w_stop     = r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
   assign w_rise     = w_scl_rise & ~w_start & ~w_stop;
   assign w_fall     = w_scl_fall & ~w_start & ~w_stop;
   assign w_bit      = r_sda_s2;

   assign w_ptr_off = r_ptr - BASE_ADDR;
   assign w_ptr_in  = w_ptr_off < 16'(DEPTH);
   assign w_ptr_idx = w_ptr_off[AW-1:0];
   assign w_usr_off = usr_addr - BASE_ADDR;
   assign w_usr_in  = w_usr_off < 16'(DEPTH);
   assign w_usr_idx = w_usr_off[AW-1:0];
   assign w_rd_byte = w_ptr_in ? r_mem[w_ptr_idx] : 8'h00;
   assign w_wr_byte = {r_shift[6:0], w_bit};

   assign w_rx_state  = (r_state == S_DEV) || (r_state == S_PTR_HI) ||
                        (r_state == S_PTR_LO) || (r_state == S_WR);
   assign w_cnt_state = w_rx_state || (r_state == S_RD);
   assign w_match     = (r_shift[7:1] == SLAVE_ADDR);
   assign w_wr_byte_end = (r_state == S_WR) && w_rise && (r_cnt == 3'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // r_shift[0] still holds the R/W bit while in DEV_ACK (no shifting there)
   always_comb begin
      w_state_nxt  = r_state;
      w_sda_oe_nxt = r_sda_oe;
      w_rd_load    = 1'b0;
      w_rd_shift   = 1'b0;
      if (w_start) begin
         w_state_nxt  = S_DEV;
         w_sda_oe_nxt = 1'b0;
      end else if (w_stop) begin
         w_state_nxt  = S_IDLE;
         w_sda_oe_nxt = 1'b0;
      end else begin
         case (r_state)
            S_DEV: if (w_fall && r_done) begin
               w_state_nxt  = w_match ? S_DEV_ACK : S_IDLE;
               w_sda_oe_nxt = w_match;
            end
            S_DEV_ACK: if (w_fall) begin
               if (r_shift[0]) begin
                  w_state_nxt  = S_RD;
                  w_sda_oe_nxt = ~w_rd_byte[7];
                  w_rd_load    = 1'b1;
               end else begin
                  w_state_nxt  = S_PTR_HI;
                  w_sda_oe_nxt = 1'b0;
               end
            end
            S_PTR_HI: if (w_fall && r_done) begin
               w_state_nxt = S_PTR_HI_ACK; w_sda_oe_nxt = 1'b1;
            end
            S_PTR_HI_ACK: if (w_fall) begin
               w_state_nxt = S_PTR_LO; w_sda_oe_nxt = 1'b0;
            end
            S_PTR_LO: if (w_fall && r_done) begin
               w_state_nxt = S_PTR_LO_ACK; w_sda_oe_nxt = 1'b1;
            end
            S_PTR_LO_ACK: if (w_fall) begin
               w_state_nxt = S_WR; w_sda_oe_nxt = 1'b0;
            end
            S_WR: if (w_fall && r_done) begin
               w_state_nxt = S_WR_ACK; w_sda_oe_nxt = 1'b1;
            end
            S_WR_ACK: if (w_fall) begin
               w_state_nxt = S_WR; w_sda_oe_nxt = 1'b0;
            end
            S_RD: if (w_fall) begin
               if (r_done) begin
                  w_state_nxt  = S_RD_ACK;
                  w_sda_oe_nxt = 1'b0;
               end else begin
                  w_sda_oe_nxt = ~r_rd_shift[6];
                  w_rd_shift   = 1'b1;
               end
            end
            S_RD_ACK: if (w_rise && w_bit) begin
               w_state_nxt = S_IDLE;
            end else if (w_fall) begin
               w_state_nxt  = S_RD;
               w_sda_oe_nxt = ~w_rd_byte[7];
               w_rd_load    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
         {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
         r_cnt      <= 3'd0;
         r_done     <= 1'b0;
         r_shift    <= 8'h00;
         r_rd_shift <= 8'h00;
         r_ptr      <= 16'h0000;
         r_sda_oe   <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= 16'h0000;
         r_wr_data  <= 8'h00;
         r_busy     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      end else begin
         {r_scl_s1, r_scl_s2, r_scl_h} <= {scl_in, r_scl_s1, r_scl_s2};
         {r_sda_s1, r_sda_s2, r_sda_h} <= {sda_in, r_sda_s1, r_sda_s2};
         r_sda_oe   <= w_sda_oe_nxt;
         r_wr_valid <= 1'b0;

         if (w_start || (w_state_nxt != r_state)) begin
            r_cnt  <= 3'd0;
            r_done <= 1'b0;
         end else if (w_rise && w_cnt_state) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_done <= 1'b1;
         end
         if (w_rise && w_rx_state) r_shift <= w_wr_byte;

         if (w_rd_load)       r_rd_shift <= w_rd_byte;
         else if (w_rd_shift) r_rd_shift <= {r_rd_shift[6:0], 1'b0};

         if (w_state_nxt == S_IDLE)         r_busy <= 1'b0;
         else if (w_state_nxt == S_DEV_ACK) r_busy <= 1'b1;

         if (r_state == S_PTR_HI && w_state_nxt == S_PTR_HI_ACK)
            r_ptr[15:8] <= r_shift;
         else if (r_state == S_PTR_LO && w_state_nxt == S_PTR_LO_ACK)
            r_ptr[7:0] <= r_shift;
         else if (w_wr_byte_end || (r_state == S_RD_ACK && w_rise && !w_bit))
            r_ptr <= r_ptr + 16'd1;

         if (w_wr_byte_end) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_ptr;
            r_wr_data  <= w_wr_byte;
            if (w_ptr_in) r_mem[w_ptr_idx] <= w_wr_byte;
         end
         // placed after the bus write so a same-register user write wins
         if (usr_we && w_usr_in) r_mem[w_usr_idx] <= usr_wdata;
      end
   end

   assign sda_oe   = r_sda_oe;
   assign wr_valid = r_wr_valid;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign busy     = r_busy;

endmodule
